// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// one-hot opcode class positions, ALU operation codes and mux encodings.
package mcu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam int CLS_W       = 8;
    localparam int CLS_RTYPE   = 0;
    localparam int CLS_ITYPE   = 1;
    localparam int CLS_MOVE    = 2;
    localparam int CLS_LOAD    = 3;
    localparam int CLS_STORE   = 4;
    localparam int CLS_BRANCH  = 5;
    localparam int CLS_JUMP    = 6;
    localparam int CLS_ILLEGAL = 7;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mcu_opcode_decoder.sv
// Combinational opcode -> one-hot class decode. Byte loads/stores (001001,
// 010001) are recognised only when MCU_BYTE_OPS_EN is defined; otherwise illegal.
module mcu_opcode_decoder
    import mcu_pkg::*;
(
    input  logic [5:0]       opcode_i,
    output logic [CLS_W-1:0] class_o,
    output logic             byte_o
);

    always_comb begin
        class_o = '0;
        byte_o  = 1'b0;
        if (opcode_i == 6'b000000) begin
            class_o[CLS_RTYPE] = 1'b1;
        end else if (opcode_i == 6'b001000) begin
            class_o[CLS_LOAD] = 1'b1;
        end else if (opcode_i == 6'b010000) begin
            class_o[CLS_STORE] = 1'b1;
`ifdef MCU_BYTE_OPS_EN
        end else if (opcode_i == 6'b001001) begin
            class_o[CLS_LOAD] = 1'b1;
            byte_o            = 1'b1;
        end else if (opcode_i == 6'b010001) begin
            class_o[CLS_STORE] = 1'b1;
            byte_o             = 1'b1;
`endif
        end else if (opcode_i == 6'b100000) begin
            class_o[CLS_MOVE] = 1'b1;
        end else if (opcode_i[5:3] == 3'b111) begin
            class_o[CLS_JUMP] = 1'b1;
        end else if (opcode_i[5] && (opcode_i[1:0] == 2'b11)) begin
            class_o[CLS_BRANCH] = 1'b1;
        end else if ((opcode_i[5:3] == 3'b000) || opcode_i[5]) begin
            // 000xxx and the remaining 100/101/110 groups are ALU immediates
            class_o[CLS_ITYPE] = 1'b1;
        end else begin
            class_o[CLS_ILLEGAL] = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM with memory wait timeout and sticky fault flags.
// Byte load/store support is enabled by defining MCU_BYTE_OPS_EN.
//
// state  | meaning
// IDLE   | post-reset, all outputs low
// FETCH  | instruction read, PC += 4 on mem_ready
// DECODE | register read, branch target calc, jumps retire
// EXEC   | ALU op / address calc / branch compare
// MEM    | data memory access
// WB     | register file write
// ERR    | fault trap, left only by reset
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               move,
    output logic               byte_op,
    output logic               branch,
    output logic               jump,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal_op,
    output logic               mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              mem_err_q, mem_err_d;
    logic [CLS_W-1:0]  cls;
    logic              is_byte;
    logic              wait_expired;

    mcu_opcode_decoder u_dec (
        .opcode_i (opcode),
        .class_o  (cls),
        .byte_o   (is_byte)
    );

    assign wait_expired = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign illegal_op   = illegal_q;
    assign mem_err      = mem_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        illegal_d  = illegal_q;
        mem_err_d  = mem_err_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        move       = 1'b0;
        byte_op    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        alu_op     = '0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_W'(ALU_ADD);
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                // a ready arriving on the last allowed cycle still completes
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALUOP_W'(ALU_ADD);
                if (cls[CLS_ILLEGAL]) begin
                    state_d   = ST_ERR;
                    illegal_d = 1'b1;
                end else if (cls[CLS_JUMP]) begin
                    jump     = 1'b1;
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_src_a = 1'b1;
                if (cls[CLS_RTYPE]) begin
                    alu_src_b = SRCB_REG;
                    alu_op    = ALUOP_W'(ALU_RTYPE);
                    state_d   = ST_WB;
                end else if (cls[CLS_ITYPE] || cls[CLS_MOVE]) begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_W'(opcode[2:0]);
                    state_d   = ST_WB;
                end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_W'(ALU_ADD);
                    state_d   = ST_MEM;
                end else if (cls[CLS_BRANCH]) begin
                    alu_src_b = SRCB_REG;
                    alu_op    = ALUOP_W'(ALU_SUB);
                    branch    = 1'b1;
                    pc_src    = PCSRC_ALUOUT;
                    state_d   = ST_FETCH;
                end else begin
                    // opcode changed under us to something not executable here
                    state_d   = ST_ERR;
                    illegal_d = 1'b1;
                end
            end

            ST_MEM: begin
                i_or_d    = 1'b1;
                byte_op   = is_byte;
                mem_read  = cls[CLS_LOAD];
                mem_write = cls[CLS_STORE];
                if (!(cls[CLS_LOAD] || cls[CLS_STORE])) begin
                    state_d   = ST_ERR;
                    illegal_d = 1'b1;
                end else if (mem_ready) begin
                    state_d = cls[CLS_LOAD] ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = cls[CLS_RTYPE];
                mem_to_reg = cls[CLS_LOAD];
                byte_op    = cls[CLS_LOAD] & is_byte;
                move       = cls[CLS_MOVE];
                state_d    = ST_FETCH;
            end

            ST_ERR: state_d = ST_ERR;

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (default parameters).
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
    logic       reg_dst, mem_to_reg, move, byte_op, branch, jump, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       illegal_op, mem_err;
    logic [21:0] ovec;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .move       (move),
        .byte_op    (byte_op),
        .branch     (branch),
        .jump       (jump),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .mem_err    (mem_err)
    );

    // bit 1 = illegal_op, bit 0 = mem_err
    assign ovec = {mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
                   reg_dst, mem_to_reg, move, byte_op, branch, jump, alu_src_a,
                   alu_src_b, pc_src, alu_op, illegal_op, mem_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 32'(ovec), 0);
        rst_n = 1'b1;
        #1;
        chk("idle_after_release", 32'(ovec), 0);
        tick();
        chk("first_fetch_read", 32'(mem_read), 1);
        chk("first_fetch_srcb", 32'(alu_src_b), 2'b01);
        chk("first_fetch_irw_noready", 32'(ir_write), 0);

        // R-type, zero wait
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        #1;
        chk("r_fetch_irw", 32'(ir_write), 1);
        chk("r_fetch_pcw", 32'(pc_write), 1);
        tick();
        chk("r_dec_srcb", 32'(alu_src_b), 2'b11);
        chk("r_dec_regw", 32'(reg_write), 0);
        tick();
        chk("r_ex_aluop", 32'(alu_op), 3'b010);
        chk("r_ex_srcb", 32'(alu_src_b), 2'b00);
        chk("r_ex_srca", 32'(alu_src_a), 1);
        chk("r_ex_regw", 32'(reg_write), 0);
        tick();
        chk("r_wb_regw", 32'(reg_write), 1);
        chk("r_wb_regdst", 32'(reg_dst), 1);
        tick();
        chk("r_next_fetch_read", 32'(mem_read), 1);
        chk("r_next_fetch_regw", 32'(reg_write), 0);

        // lw with three MEM wait cycles, WB on cycle 8
        opcode = 6'b001000;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("lw_ex_aluop", 32'(alu_op), 3'b000);
        chk("lw_ex_srcb", 32'(alu_src_b), 2'b10);
        tick();
        chk("lw_mem_read", 32'(mem_read), 1);
        chk("lw_mem_iord", 32'(i_or_d), 1);
        tick();
        tick();
        tick();
        chk("lw_mem_still_waiting", 32'(mem_read & i_or_d), 1);
        mem_ready = 1'b1;
        tick();
        chk("lw_wb_memtoreg", 32'(mem_to_reg), 1);
        chk("lw_wb_regw", 32'(reg_write), 1);
        chk("lw_wb_regdst", 32'(reg_dst), 0);
        tick();

        // opcode garbage during FETCH is ignored; I-type 000101
        mem_ready = 1'b0;
        opcode    = 6'b011000;
        #1;
        chk("fetch_wait_irw", 32'(ir_write), 0);
        tick();
        chk("fetch_garbage_read", 32'(mem_read), 1);
        chk("fetch_garbage_noflag", 32'(illegal_op), 0);
        opcode    = 6'b000101;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("i_ex_aluop", 32'(alu_op), 3'b101);
        chk("i_ex_srcb", 32'(alu_src_b), 2'b10);
        tick();
        chk("i_wb_regw_dst", 32'({reg_write, reg_dst, mem_to_reg}), 3'b100);
        tick();

        // jump 111010
        opcode = 6'b111010;
        tick();
        chk("j_dec_pcw", 32'(pc_write), 1);
        chk("j_dec_pcsrc", 32'(pc_src), 2'b10);
        chk("j_dec_jump", 32'(jump), 1);
        tick();
        chk("j_next_fetch", 32'({mem_read, jump}), 2'b10);

        // branch 100111
        opcode = 6'b100111;
        tick();
        tick();
        chk("b_ex_branch", 32'(branch), 1);
        chk("b_ex_pcsrc", 32'(pc_src), 2'b01);
        chk("b_ex_aluop", 32'(alu_op), 3'b001);
        chk("b_ex_srcb", 32'(alu_src_b), 2'b00);
        tick();
        chk("b_next_fetch", 32'({mem_read, branch}), 2'b10);

        // sw 010000
        opcode = 6'b010000;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk("sw_mem_strobes", 32'({mem_read, mem_write, i_or_d, byte_op}), 4'b0110);
        mem_ready = 1'b1;
        tick();
        chk("sw_next_fetch", 32'({mem_read, mem_write}), 2'b10);

        // move 100000
        opcode = 6'b100000;
        tick();
        tick();
        chk("mv_ex_aluop", 32'(alu_op), 3'b000);
        tick();
        chk("mv_wb", 32'({reg_write, move, reg_dst}), 3'b110);
        tick();

        // ready on the 15th FETCH cycle wins over the timeout
        opcode    = 6'b111000;
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("tmo_edge_still_fetch", 32'({mem_read, mem_err}), 2'b10);
        mem_ready = 1'b1;
        tick();
        chk("tmo_edge_decode_jump", 32'(jump), 1);
        chk("tmo_edge_no_fault", 32'(mem_err), 0);
        tick();

        // reset during a MEM store
        opcode = 6'b010000;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_pre_memwrite", 32'(mem_write), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_memwrite_drop", 32'(mem_write), 0);
        chk("rst_all_zero", 32'(ovec), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_idle", 32'(ovec), 0);
        tick();
        chk("rst_then_fetch", 32'(mem_read), 1);

        // FETCH timeout: 15 wait cycles then ERR
        for (int i = 0; i < 14; i++) tick();
        chk("tmo_cycle15", 32'({mem_read, mem_err}), 2'b10);
        tick();
        chk("tmo_err", 32'(ovec), 22'h000001);
        mem_ready = 1'b1;
        tick();
        tick();
        chk("tmo_err_sticky", 32'(ovec), 22'h000001);

        // illegal 011000
        do_reset();
        opcode    = 6'b011000;
        mem_ready = 1'b1;
        tick();
        chk("ill_dec_noflag_yet", 32'(illegal_op), 0);
        tick();
        chk("ill_err", 32'(ovec), 22'h000002);
        tick();
        chk("ill_err_sticky", 32'(ovec), 22'h000002);

        // sb 010001
        do_reset();
        opcode    = 6'b010001;
        mem_ready = 1'b1;
        tick();
        tick();
`ifdef MCU_BYTE_OPS_EN
        chk("sb_ex_aluop", 32'(alu_op), 3'b000);
        mem_ready = 1'b0;
        tick();
        chk("sb_mem", 32'({mem_write, byte_op, illegal_op}), 3'b110);
`else
        chk("sb_illegal", 32'(ovec), 22'h000002);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
